// File: rtl/neuron_wxor_if.sv
// Signal bundle between the pulse front-end and one signed-accumulate neuron.
interface neuron_wxor_if #(
  parameter int DATA_W = 8
);
  logic              tac_in;
  logic              sign_x;
  logic              sign_w;
  logic [DATA_W-1:0] win;
  logic [DATA_W-1:0] bias;
  logic [DATA_W-1:0] dout;

  modport master (
    output tac_in, sign_x, sign_w, win, bias,
    input  dout
  );

  modport slave (
    input  tac_in, sign_x, sign_w, win, bias,
    output dout
  );
endinterface

// File: rtl/neuron_wxor.sv
// Signed-accumulate neuron: adds or subtracts the weight magnitude on each
// input pulse (direction = sign_x ^ sign_w), keeps a saturating signed
// accumulator, and registers ReLU(acc + bias) clamped to DATA_W bits.
module neuron_wxor #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  neuron_wxor_if.slave  bus
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W:0]    step_ext;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W:0]    out_sum;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_next;
  logic              neg;

  // Step, saturating accumulate, and output stage computed from acc_next.
  // All sums are one bit wider than the accumulator so the sign survives.
  always_comb begin
    neg      = bus.sign_x ^ bus.sign_w;
    step_ext = {{(ACC_W+1-DATA_W){1'b0}}, bus.win};
    if (neg) begin
      step_ext = ~step_ext + 1'b1;
    end
    acc_sum = {acc[ACC_W-1], acc} + step_ext;

    acc_next = acc;
    if (bus.tac_in) begin
      // Top two bits disagree only when the result left the ACC_W range.
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
        acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_next = acc_sum[ACC_W-1:0];
      end
    end

    out_sum = {acc_next[ACC_W-1], acc_next} + {{(ACC_W+1-DATA_W){1'b0}}, bus.bias};

    if (out_sum[ACC_W]) begin
      dout_next = '0;
    end else if (|out_sum[ACC_W-1:DATA_W]) begin
      dout_next = '1;
    end else begin
      dout_next = out_sum[DATA_W-1:0];
    end
  end

  // State registers; reset wins over an accumulate pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc    <= '0;
      dout_q <= '0;
    end else begin
      acc    <= acc_next;
      dout_q <= dout_next;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_neuron_wxor.sv
// Directed bench for neuron_wxor with hand-computed expected values.
module tb_neuron_wxor;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  neuron_wxor_if #(.DATA_W(8)) bus ();

  neuron_wxor #(.DATA_W(8), .ACC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int exp_acc, input int exp_dout);
    check({tag, ".acc"}, int'($signed(dut.acc)), exp_acc);
    check({tag, ".dout"}, int'(bus.dout), exp_dout);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    chk("reset", 0, 0);
    rst = 1'b1;
  endtask

  task automatic set_in(input bit t, input bit sx, input bit sw, input int w, input int b);
    bus.tac_in = t;
    bus.sign_x = sx;
    bus.sign_w = sw;
    bus.win    = 8'(w);
    bus.bias   = 8'(b);
  endtask

  initial begin
    int exp_acc;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;

    // Reset held for two edges with an active pulse, then positive accumulate.
    set_in(1, 1, 1, 150, 100);
    tick(); chk("t1.rst0", 0, 0);
    tick(); chk("t1.rst1", 0, 0);
    rst = 1'b1;
    tick(); chk("t1.e1", 150, 250);
    tick(); chk("t1.e2", 300, 255);

    // Negative steps clipped by ReLU, then back up.
    do_reset();
    set_in(1, 1, 0, 200, 120);
    tick(); chk("t2.e1", -200, 0);
    tick(); chk("t2.e2", -400, 0);
    bus.sign_w = 1'b1;
    tick(); chk("t2.e3", -200, 0);
    tick(); chk("t2.e4", 0, 120);

    // Max step and bias; accumulator clamps at 32767.
    do_reset();
    set_in(1, 1, 1, 255, 255);
    for (int k = 1; k <= 130; k++) begin
      tick();
      exp_acc = (255 * k > 32767) ? 32767 : 255 * k;
      chk($sformatf("t3.e%0d", k), exp_acc, 255);
    end
    bus.sign_w = 1'b0;
    tick(); chk("t3.down", 32512, 255);

    // Reset in the middle of accumulation discards state.
    do_reset();
    set_in(1, 0, 0, 180, 200);
    tick(); chk("t4.e1", 180, 255);
    tick(); chk("t4.e2", 360, 255);
    tick(); chk("t4.e3", 540, 255);
    rst = 1'b0;
    tick(); chk("t4.rst", 0, 0);
    rst = 1'b1;
    tick(); chk("t4.rel", 180, 255);

    // Bias changes alone while holding a nonzero accumulator.
    set_in(0, 0, 0, 100, 10);
    tick(); chk("t4.hold1", 180, 190);
    bus.bias = 8'd80;
    tick(); chk("t4.hold2", 180, 255);

    // Zero step with bias only, then hold, then accumulate.
    do_reset();
    set_in(1, 0, 1, 0, 150);
    tick(); chk("t5.z1", 0, 150);
    tick(); chk("t5.z2", 0, 150);
    tick(); chk("t5.z3", 0, 150);
    set_in(0, 0, 0, 100, 0);
    tick(); chk("t5.hold", 0, 0);
    bus.tac_in = 1'b1;
    tick(); chk("t5.a1", 100, 100);
    tick(); chk("t5.a2", 200, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_wxor.md
Name: neuron_wxor

Overview:
Single signed-accumulate neuron for the time/pulse-coded inference datapath. On every clock where the input pulse `tac_in` is high, it adds or subtracts the 8-bit weight magnitude `win` into a signed accumulator. The add/subtract choice is `sign_x XOR sign_w`. The registered output `dout` is the accumulator plus an unsigned bias, passed through a ReLU and saturated to 8 bits. It sits between the spike/pulse front-end and the next layer's input register.

Parameters:
- DATA_W, 8, width of `win`, `bias` and `dout` (unsigned magnitudes).
- ACC_W, 16, width of the signed two's-complement accumulator; must be ≥ DATA_W+2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising edge of `clk`.
- tac_in  in  1  accumulate enable / input pulse for this cycle.
- sign_x  in  1  sign of input activation (1 and 0 treated symmetrically; only the XOR matters).
- sign_w  in  1  sign of weight.
- win  in  DATA_W  unsigned weight magnitude (step size).
- bias  in  DATA_W  unsigned bias, added combinationally before output stage.
- dout  out  DATA_W  registered ReLU-saturated neuron output.

Behaviour:
- Reset: rising edge with `rst`=0 → accumulator = 0 and `dout` = 0. Reset has priority over `tac_in`. Reset mid-accumulation discards all accumulated state.
- Effective sign: neg = `sign_x ^ sign_w`.
  - neg=0 → step = +`win`.
  - neg=1 → step = −`win`.
- Accumulate: rising edge with `rst`=1 and `tac_in`=1 → acc_next = sat_acc(acc + step). Otherwise acc_next = acc (hold).
- Accumulator saturation: clamp to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. No wrap-around.
- Output: every rising edge with `rst`=1:
  - sum = acc_next + zero_ext(`bias`), computed at ACC_W+1 bits, signed.
  - `dout` ← 0 if sum < 0.
  - `dout` ← 2^DATA_W−1 if sum > 2^DATA_W−1.
  - `dout` ← sum otherwise.
- Latency: `dout` after edge k reflects all `tac_in` pulses up to and including edge k, and the `bias` sampled at edge k (1-cycle registered latency from inputs).
- `bias` is not stored; a change in `bias` alone updates `dout` on the next edge.
- `win`=0 with `tac_in`=1: acc unchanged. Still counts as a legal accumulate cycle.
- `tac_in`=0: acc holds; `dout` still recomputed from the held acc and current `bias`.
- All inputs are assumed synchronous to `clk`; no handshake and no back-pressure.

Test Plan:
- Reset then positive accumulate:
  - Stimulus: `rst`=0 for 2 edges; release; `tac_in`=1, `win`=150, `sign_x`=`sign_w`=1, `bias`=100.
  - Response: `dout`=0 during reset; after edge 1 acc=150, `dout`=250; after edge 2 acc=300, `dout`=255 (saturated).
- Negative step with ReLU:
  - Stimulus: from acc=0, `sign_x`=1, `sign_w`=0, `win`=200, `bias`=120, `tac_in`=1.
  - Response: acc=−200 → `dout`=0; acc=−400 → `dout`=0.
  - Then flip `sign_w`=1: acc returns to −200 → `dout`=0; next edge acc=0 → `dout`=120.
- Max values and accumulator saturation:
  - Stimulus: `win`=255, `bias`=255, same signs, `tac_in`=1 for 130 edges.
  - Response: `dout`=255 from edge 1; acc stops at 32767 (no wrap); one −255 step then gives 32512.
- Reset mid-operation:
  - Stimulus: `win`=180, `bias`=200, same signs; 3 accumulate edges (acc=540, `dout`=255); then `rst`=0 for 1 edge.
  - Response: `dout`=0 and acc=0 that edge.
  - After release: next edge acc=180, `dout`=255.
- Zero step with bias only, and hold:
  - Stimulus: from reset, `win`=0, `bias`=150, `tac_in`=1.
  - Response: `dout`=150 constant.
  - Then `tac_in`=0, `win`=100, `bias`=0 → `dout`=0 and acc held at 0.
  - Then `tac_in`=1 → `dout`=100, then 200.
